// File: rtl/swap_mem_unit.sv
// Atomic swap unit: reads a word/halfword from data memory, writes rs2 back
// under a bus lock, and returns the loaded value for rd writeback.
module swap_mem_unit #(
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_lock,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready
);
    typedef enum logic [2:0] {IDLE, LOAD, LOAD_WAIT, STORE, DONE} state_t;
    typedef enum logic [1:0] {OP_LH, OP_LW, OP_LHU} op_t;

    localparam logic [6:0] OPC_SWAP = 7'b1101011;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        half_hi_q, half_hi_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_lock_q, mem_lock_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    op_t         req_op;
    logic        req_legal;
    logic        req_misaligned;
    logic [15:0] rd_half;
    logic [31:0] rd_value;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{req_instr[31:15], req_instr[11:7]};

    always_comb begin
        req_op    = OP_LW;
        req_legal = 1'b0;
        if (req_instr[6:0] == OPC_SWAP) begin
            case (req_instr[14:12])
                3'b001:  begin req_op = OP_LH;  req_legal = 1'b1; end
                3'b010:  begin req_op = OP_LW;  req_legal = 1'b1; end
                3'b101:  begin req_op = OP_LHU; req_legal = 1'b1; end
                default: begin req_op = OP_LW;  req_legal = 1'b0; end
            endcase
        end
        if (CHECK_ALIGN != 0)
            req_misaligned = (req_op == OP_LW) ? (req_addr[1:0] != 2'b00) : req_addr[0];
        else
            req_misaligned = 1'b0;
    end

    always_comb begin
        rd_half = half_hi_q ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LW:   rd_value = mem_rdata;
            OP_LH:   rd_value = {{16{rd_half[15]}}, rd_half};
            default: rd_value = {16'h0000, rd_half};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        half_hi_d   = half_hi_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_lock_d  = mem_lock_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!req_legal || req_misaligned) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d     = LOAD;
                        op_d        = req_op;
                        half_hi_d   = req_addr[1];
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_lock_d  = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        if (req_op == OP_LW) begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = req_wdata;
                        end else begin
                            mem_be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                            mem_wdata_d = {req_wdata[15:0], req_wdata[15:0]};
                        end
                    end
                end
            end
            LOAD: begin
                if (mem_gnt) begin
                    state_d   = LOAD_WAIT;
                    mem_req_d = 1'b0;
                end
            end
            LOAD_WAIT: begin
                // Loaded value parks in rsp_data; rsp_valid stays low until DONE.
                if (mem_rvalid) begin
                    state_d    = STORE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    rsp_data_d = rd_value;
                end
            end
            STORE: begin
                if (mem_gnt) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_lock_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_LW;
            half_hi_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_lock_q  <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            half_hi_q   <= half_hi_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_lock_q  <= mem_lock_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_lock  = mem_lock_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_swap_mem_unit.sv
// Bench for swap_mem_unit: vector table, handshake scoreboard, and a small
// memory responder with programmable grant and read-data delays.
module tb_swap_mem_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_instr, req_addr, req_wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_lock;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err, rsp_ready;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    swap_mem_unit #(.CHECK_ALIGN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_lock(mem_lock),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready)
    );

    localparam logic [6:0] OPC = 7'b1101011;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder state
    logic [31:0] mem [0:255];
    int          gnt_delay = 0;
    int          rd_delay = 1;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          rvalid_count = 0;
    bit          in_swap = 1'b0;
    logic [31:0] rd_addr_seen, wr_addr_seen, wr_wdata_seen;
    logic [3:0]  wr_be_seen;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;

    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem[rd_addr_seen[9:2]];
                    rvalid_count++;
                end
            end
            mem_gnt = 1'b0;
            if (rst) begin
                in_swap = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                chk("mem_lock_while_req", {31'b0, mem_lock}, 32'd1);
                if (wait_cnt == 0) begin
                    snap_addr = mem_addr; snap_wdata = mem_wdata;
                    snap_be = mem_be; snap_we = mem_we;
                end else begin
                    chk("stall_addr_stable", mem_addr, snap_addr);
                    chk("stall_be_stable", {28'b0, mem_be}, {28'b0, snap_be});
                    chk("stall_we_stable", {31'b0, mem_we}, {31'b0, snap_we});
                    chk("stall_wdata_stable", mem_wdata, snap_wdata);
                end
                if (wait_cnt == gnt_delay) begin
                    mem_gnt = 1'b1;
                    wait_cnt = 0;
                    if (!mem_we) begin
                        rd_count++;
                        rd_addr_seen = mem_addr;
                        rd_cnt = rd_delay;
                        in_swap = 1'b1;
                    end else begin
                        wr_count++;
                        wr_addr_seen = mem_addr;
                        wr_be_seen = mem_be;
                        wr_wdata_seen = mem_wdata;
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                        in_swap = 1'b0;
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (in_swap) begin
                chk("mem_lock_load_wait", {31'b0, mem_lock}, 32'd1);
            end
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mem;
        int          exp_lat;
    } vec_t;
    vec_t vecs[12];

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_mem_lock"}, {31'b0, mem_lock}, 32'd0);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    endtask

    task automatic do_swap(input logic [31:0] instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_data, input int exp_lat,
                           input int stall_rsp);
        exp_t e, got;
        int cyc;
        logic [31:0] held_data;
        e.err = exp_err;
        e.data = exp_data;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_instr = instr; req_addr = addr; req_wdata = wdata;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            #1 cyc++;
        end
        if (!rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles expected response", cyc);
            void'(sb.pop_front());
            return;
        end
        if (exp_lat >= 0) chk("rsp_latency", cyc, exp_lat);
        chk("lock_off_in_done", {31'b0, mem_lock}, 32'd0);
        held_data = rsp_data;
        for (int i = 0; i < stall_rsp; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_rsp_data", rsp_data, held_data);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: got response %h expected no response", rsp_data);
        end else begin
            got = sb.pop_front();
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, got.err});
            chk("rsp_data", rsp_data, got.data);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
        chk("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int stall_rsp);
        logic [31:0] rnd, instr;
        int r0, w0;
        rnd = $urandom;
        instr = {rnd[31:15], v.f3, rnd[11:7], v.opc};
        mem[v.addr[9:2]] = v.init;
        r0 = rd_count;
        w0 = wr_count;
        do_swap(instr, v.addr, v.wdata, v.exp_err, v.exp_data, v.exp_lat, stall_rsp);
        if (!v.exp_err) begin
            chk("read_count", rd_count - r0, 1);
            chk("write_count", wr_count - w0, 1);
            chk("read_addr", rd_addr_seen, {v.addr[31:2], 2'b00});
            chk("write_addr", wr_addr_seen, {v.addr[31:2], 2'b00});
            chk("write_be", {28'b0, wr_be_seen}, {28'b0, v.exp_be});
            chk("write_wdata", wr_wdata_seen, v.exp_wdata);
        end else begin
            chk("err_no_read", rd_count - r0, 0);
            chk("err_no_write", wr_count - w0, 0);
        end
        chk("mem_after", mem[v.addr[9:2]], v.exp_mem);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int r0, w0, v0;
        vecs[0]  = '{3'b010, OPC, 32'h100, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h12345678, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 4};
        vecs[1]  = '{3'b001, OPC, 32'h202, 32'h0000ABCD, 32'h80017777, 1'b0, 32'hFFFF8001, 4'hC, 32'hABCDABCD, 32'hABCD7777, 4};
        vecs[2]  = '{3'b101, OPC, 32'h200, 32'h00005555, 32'h1234F00F, 1'b0, 32'h0000F00F, 4'h3, 32'h55555555, 32'h12345555, 4};
        vecs[3]  = '{3'b001, OPC, 32'h200, 32'h00000001, 32'h1234F00F, 1'b0, 32'hFFFFF00F, 4'h3, 32'h00010001, 32'h12340001, 4};
        vecs[4]  = '{3'b101, OPC, 32'h202, 32'hFFFF1234, 32'h80017777, 1'b0, 32'h00008001, 4'hC, 32'h12341234, 32'h12347777, 4};
        vecs[5]  = '{3'b001, OPC, 32'h204, 32'h11112222, 32'hAAAA7FFF, 1'b0, 32'h00007FFF, 4'h3, 32'h22222222, 32'hAAAA2222, 4};
        vecs[6]  = '{3'b010, OPC, 32'h101, 32'h99999999, 32'h5A5A5A5A, 1'b1, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1};
        vecs[7]  = '{3'b011, OPC, 32'h100, 32'h99999999, 32'h5A5A5A5A, 1'b1, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1};
        vecs[8]  = '{3'b010, 7'b0110011, 32'h100, 32'h99999999, 32'h5A5A5A5A, 1'b1, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1};
        vecs[9]  = '{3'b001, OPC, 32'h201, 32'h99999999, 32'h5A5A5A5A, 1'b1, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1};
        vecs[10] = '{3'b010, OPC, 32'h102, 32'h99999999, 32'h5A5A5A5A, 1'b1, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1};
        vecs[11] = '{3'b101, OPC, 32'h203, 32'h99999999, 32'h5A5A5A5A, 1'b1, 32'h0, 4'h0, 32'h0, 32'h5A5A5A5A, 1};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_instr = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("req_ready_in_reset", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals("por");

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 0);

        // Slow grants on both accesses, response held off for two cycles.
        gnt_delay = 3;
        rsp_ready = 1'b0;
        run_vec('{3'b010, OPC, 32'h300, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 32'h0BADBEEF, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 10}, 2);
        gnt_delay = 0;

        // Reset while waiting for read data; the late rvalid must be ignored.
        rd_delay = 3;
        mem[8'h40] = 32'h11111111;
        r0 = rd_count; w0 = wr_count; v0 = rvalid_count;
        @(negedge clk);
        req_valid = 1'b1; req_instr = {17'h0, 3'b010, 5'd3, OPC};
        req_addr = 32'h100; req_wdata = 32'h77777777;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("lw_state_lock", {31'b0, mem_lock}, 32'd1);
        chk("lw_state_noreq", {31'b0, mem_req}, 32'd0);
        #1 rst = 1'b1;
        #1 chk("req_ready_rst_pulse", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_reset_vals("rst_lw");
        chk("rst_late_rvalid_seen", rvalid_count - v0, 1);
        chk("rst_read_count", rd_count - r0, 1);
        chk("rst_no_write", wr_count - w0, 0);
        chk("rst_mem_unchanged", mem[8'h40], 32'h11111111);
        rd_delay = 1;

        run_vec(vecs[0], 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/swap_mem_unit.md
SWAP_MEM_UNIT -- requirements
Module: swap_mem_unit

Interface
REQ-001 SHALL have parameter CHECK_ALIGN, default 1, meaning misaligned swaps are rejected with an error instead of accessing memory.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  upstream presents a decoded swap instruction.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_instr  input  32  raw instruction; opcode [6:0] and funct3 [14:12] select the operation.
REQ-007 SHALL have port req_addr  input  32  effective byte address (rs1+imm, computed upstream).
REQ-008 SHALL have port req_wdata  input  32  rs2 value to be stored.
REQ-009 SHALL have ports mem_req, mem_we (output 1), mem_addr, mem_wdata (output 32), mem_be (output 4)  data-memory request.
REQ-010 SHALL have ports mem_gnt, mem_rvalid (input 1) and mem_rdata (input 32)  memory grant, read-data valid, read data.
REQ-011 SHALL have port mem_lock  output  1  bus locked for an atomic read-then-write.
REQ-012 SHALL have ports rsp_valid, rsp_err (output 1), rsp_data (output 32), rsp_ready (input 1)  result to rd writeback.

Function
REQ-013 SHALL decode opcode 1101011 with funct3 001 = SWAP_LH, 010 = SWAP_LW, 101 = SWAP_LHU; any other opcode/funct3 is illegal.
REQ-014 SHALL use FSM states IDLE, LOAD, LOAD_WAIT, STORE, DONE; req_ready=1 only in IDLE.
REQ-015 SHALL capture the request on req_valid&req_ready and transition IDLE->LOAD, or IDLE->DONE with rsp_err=1 when the request is illegal or misaligned.
REQ-016 SHALL treat as misaligned (when CHECK_ALIGN=1): LW with addr[1:0]!=0; LH/LHU with addr[0]!=0. With CHECK_ALIGN=0, address bits [1:0] below the access size are ignored.
REQ-017 SHALL drive mem_addr = {addr[31:2],2'b00} for both the read and the write of one swap.
REQ-018 SHALL set mem_be = 1111 for LW; 0011 for halfword with addr[1]=0; 1100 for halfword with addr[1]=1.
REQ-019 SHALL set mem_wdata = rs2 for LW and {rs2[15:0],rs2[15:0]} for halfwords.
REQ-020 LOAD: mem_req=1, mem_we=0, held stable until mem_gnt; on mem_gnt -> LOAD_WAIT.
REQ-021 LOAD_WAIT: mem_req=0; on mem_rvalid capture the extracted value -> STORE; mem_rvalid is accepted only in LOAD_WAIT and ignored in every other state.
REQ-022 SHALL extract for LH the selected halfword sign-extended, for LHU zero-extended, and for LW the full word; the selected halfword is rdata[15:0] if addr[1]=0, else rdata[31:16].
REQ-023 STORE: mem_req=1, mem_we=1, held stable until mem_gnt; on mem_gnt -> DONE.
REQ-024 SHALL assert mem_lock from entry into LOAD through the cycle mem_gnt is seen in STORE, and never in IDLE, DONE or any error path.
REQ-025 DONE: rsp_valid=1 with rsp_data and rsp_err held stable until rsp_ready; on rsp_ready -> IDLE; rsp_data=0 when rsp_err=1.
REQ-026 SHALL NOT issue any memory request for an erroneous swap.
REQ-027 Minimum latency with mem_gnt immediate and mem_rvalid one cycle after grant: accept at cycle 0, read granted at 1, rvalid at 2, write granted at 3, rsp_valid at 4.
REQ-028 SHALL keep req_ready=0 while rsp_valid is stalled by rsp_ready=0, so no new request is accepted.

Reset
REQ-029 rst=1 SHALL force IDLE on the next edge, regardless of state.
REQ-030 Reset values: req_ready=1 (0 while rst is asserted), mem_req=0, mem_we=0, mem_lock=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_data=0.
REQ-031 Reset in LOAD_WAIT or STORE SHALL abandon the swap without a write; a late mem_rvalid after reset is ignored.

Verification
REQ-032 LW at 0x100, rs2=0xDEADBEEF, mem holds 0x12345678, zero-wait memory -> read then write be=1111; rsp_data=0x12345678 at cycle 4; memory becomes 0xDEADBEEF.
REQ-033 LH at 0x202, rs2=0x0000ABCD, word=0x8001_7777 -> be=1100, wdata=0xABCDABCD, rsp_data=0xFFFF8001.
REQ-034 LHU at 0x200, word=0x1234_F00F -> be=0011, rsp_data=0x0000F00F.
REQ-035 LW at 0x101 (CHECK_ALIGN=1), or funct3=011 -> no mem_req, rsp_valid with rsp_err=1, rsp_data=0.
REQ-036 Grant delayed 3 cycles on each access, and rsp_ready low for 2 cycles -> mem_req/mem_addr/mem_be stable while waiting, mem_lock continuous LOAD..STORE, req_ready=0 until the response handshake.
REQ-037 rst pulsed in LOAD_WAIT, then mem_rvalid arrives -> no write issued, unit in IDLE with all outputs at reset values.
